// File: rtl/except_ctrl_pkg.sv
// rtl/except_ctrl_pkg.sv - shared constants, flag layout and FSM states for except_ctrl
//
// Purpose: cause codes, exception vector, status/cause bit positions,
//          i_exc_flags bit positions, the FSM state type and the fault
//          priority encoder used by except_ctrl.
// Ports:   none (package).

package except_ctrl_pkg;

  localparam int INT_W  = 6;
  localparam int FLAG_W = 7;

  // Exception cause codes
  localparam logic [4:0] CAUSE_INT  = 5'd0;
  localparam logic [4:0] CAUSE_ADEL = 5'd4;
  localparam logic [4:0] CAUSE_ADES = 5'd5;
  localparam logic [4:0] CAUSE_SYS  = 5'd8;
  localparam logic [4:0] CAUSE_BP   = 5'd9;
  localparam logic [4:0] CAUSE_RI   = 5'd10;
  localparam logic [4:0] CAUSE_OV   = 5'd12;
  localparam logic [4:0] CAUSE_NONE = 5'h1F;

  // Fetch target for every exception (ERET uses EPC instead)
  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  // Status register bit positions
  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int IM_LO      = 8;
  localparam int IM_HI      = 15;

  // Cause register interrupt-pending field
  localparam int IP_LO = 8;
  localparam int IP_HI = 15;

  // i_exc_flags layout: {adel_if, ri, sys, bp, ov, adel_mem, ades_mem}
  localparam int FLAG_ADEL_IF  = 6;
  localparam int FLAG_RI       = 5;
  localparam int FLAG_SYS      = 4;
  localparam int FLAG_BP       = 3;
  localparam int FLAG_OV       = 2;
  localparam int FLAG_ADEL_MEM = 1;
  localparam int FLAG_ADES_MEM = 0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  // Highest-priority instruction fault, or CAUSE_NONE if no flag is set.
  // Fetch faults outrank decode faults, which outrank memory faults,
  // matching the order in which the instruction would have met them.
  function automatic logic [4:0] fault_code(input logic [FLAG_W-1:0] flags);
    logic [4:0] code;
    code = CAUSE_NONE;
    if (flags[FLAG_ADEL_IF])       code = CAUSE_ADEL;
    else if (flags[FLAG_RI])       code = CAUSE_RI;
    else if (flags[FLAG_SYS])      code = CAUSE_SYS;
    else if (flags[FLAG_BP])       code = CAUSE_BP;
    else if (flags[FLAG_OV])       code = CAUSE_OV;
    else if (flags[FLAG_ADEL_MEM]) code = CAUSE_ADEL;
    else if (flags[FLAG_ADES_MEM]) code = CAUSE_ADES;
    return code;
  endfunction

endpackage

// File: rtl/except_ctrl_int_sync.sv
// rtl/except_ctrl_int_sync.sv - optional two-flop synchroniser for external interrupt lines
//
// Purpose: passes the external interrupt lines to the controller, either
//          through a two-flop synchroniser (EXCEPT_INT_SYNC_EN defined,
//          2-cycle latency, flops cleared in reset) or combinationally.
// Ports:   clk     - clock
//          resetn  - synchronous active-low reset
//          ext_int - asynchronous external interrupt lines
//          int_s   - interrupt lines in the clk domain
// Macro:   EXCEPT_INT_SYNC_EN

module int_sync
  import except_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic [INT_W-1:0] ext_int,
  output logic [INT_W-1:0] int_s
);

`ifdef EXCEPT_INT_SYNC_EN
  logic [INT_W-1:0] meta_q;
  logic [INT_W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= ext_int;
      sync_q <= meta_q;
    end
  end

  assign int_s = sync_q;
`else
  // Clock and reset are only needed by the synchronised build.
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, resetn};

  assign int_s = ext_int;
`endif

endmodule

// File: rtl/except_ctrl.sv
// rtl/except_ctrl.sv - memory-stage exception/interrupt controller with flush and redirect FSM
//
// Purpose: picks the highest-priority event (interrupt, instruction fault or
//          ERET) for the memory-stage instruction, strobes the coprocessor
//          update fields with a one-cycle flush, then holds a fetch redirect
//          until fetch accepts it.
// Ports:   clk, resetn            - clock, synchronous active-low reset
//          i_valid                - memory-stage instruction present
//          i_pc                   - its PC
//          i_is_in_delay_slot     - it sits in a branch delay slot
//          i_exc_flags            - {adel_if, ri, sys, bp, ov, adel_mem, ades_mem}
//          i_is_eret              - it is ERET
//          i_ext_int, i_timer_int - interrupt sources
//          i_status_reg, i_cause_reg, i_epc_reg - coprocessor register values
//          i_fetch_ready          - fetch accepts the redirect
//          o_int                  - interrupt lines to the coprocessor
//          o_except_cause, o_current_pc, o_is_in_delay_slot, o_is_eret
//                                 - coprocessor update strobe fields
//          o_flush, o_stall       - pipeline kill / freeze
//          o_redirect_valid, o_redirect_pc - new fetch target
// Macro:   EXCEPT_INT_SYNC_EN (synchronise i_ext_int, see int_sync)

module except_ctrl
  import except_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_valid,
  input  logic [31:0]       i_pc,
  input  logic              i_is_in_delay_slot,
  input  logic [FLAG_W-1:0] i_exc_flags,
  input  logic              i_is_eret,
  input  logic [INT_W-1:0]  i_ext_int,
  input  logic              i_timer_int,
  input  logic [31:0]       i_status_reg,
  input  logic [31:0]       i_cause_reg,
  input  logic [31:0]       i_epc_reg,
  input  logic              i_fetch_ready,
  output logic [INT_W-1:0]  o_int,
  output logic [4:0]        o_except_cause,
  output logic [31:0]       o_current_pc,
  output logic              o_is_in_delay_slot,
  output logic              o_is_eret,
  output logic              o_flush,
  output logic              o_stall,
  output logic              o_redirect_valid,
  output logic [31:0]       o_redirect_pc
);

  // ---------------------------------------------------------------
  // Interrupt lines
  // ---------------------------------------------------------------
  logic [INT_W-1:0] int_s;

  int_sync u_int_sync (
    .clk     (clk),
    .resetn  (resetn),
    .ext_int (i_ext_int),
    .int_s   (int_s)
  );

  // The timer shares hardware line 5 with the top external line.
  assign o_int = {int_s[INT_W-1] | i_timer_int, int_s[INT_W-2:0]};

  // Pending is judged from the live coprocessor registers, so an interrupt
  // that arrives while a flush/redirect is in flight is simply seen again
  // once the FSM is back in IDLE.
  logic int_pending;
  assign int_pending = i_status_reg[STATUS_IE] & ~i_status_reg[STATUS_EXL] &
                       (|(i_cause_reg[IP_HI:IP_LO] & i_status_reg[IM_HI:IM_LO]));

  // Register bits this block does not look at.
  logic unused_reg_bits;
  assign unused_reg_bits = &{1'b0, i_status_reg[31:16], i_status_reg[7:2],
                             i_cause_reg[31:16], i_cause_reg[7:0]};

  // ---------------------------------------------------------------
  // Event selection
  // ---------------------------------------------------------------
  logic [4:0] fault;
  logic [4:0] take_cause;
  logic       take_eret;
  logic       take_event;

  always_comb begin
    fault      = fault_code(i_exc_flags);
    take_cause = CAUSE_NONE;
    take_eret  = 1'b0;
    // An interrupt flushes the instruction, so any fault it carries is moot;
    // ERET only counts when the instruction itself is clean.
    if (int_pending) begin
      take_cause = CAUSE_INT;
    end else if (fault != CAUSE_NONE) begin
      take_cause = fault;
    end else if (i_is_eret) begin
      take_eret = 1'b1;
    end
    take_event = i_valid && ((take_cause != CAUSE_NONE) || take_eret);
  end

  // ---------------------------------------------------------------
  // FSM and captured fields
  // ---------------------------------------------------------------
  state_t      state_q;
  state_t      state_d;
  logic [4:0]  cause_q;
  logic [31:0] pc_q;
  logic        slot_q;
  logic        eret_q;
  logic [31:0] redirect_pc_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      cause_q       <= '0;
      pc_q          <= '0;
      slot_q        <= 1'b0;
      eret_q        <= 1'b0;
      redirect_pc_q <= EXC_VECTOR;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && take_event) begin
        cause_q <= take_cause;
        pc_q    <= i_pc;
        slot_q  <= i_is_in_delay_slot;
        eret_q  <= take_eret;
      end
      // EPC is sampled while the flush strobe is out; later EPC writes do
      // not disturb a redirect already being presented.
      if (state_q == FLUSH) begin
        redirect_pc_q <= eret_q ? i_epc_reg : EXC_VECTOR;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    o_flush          = 1'b0;
    o_stall          = 1'b0;
    o_redirect_valid = 1'b0;
    o_except_cause   = CAUSE_NONE;
    o_is_eret        = 1'b0;
    case (state_q)
      IDLE: begin
        if (take_event) state_d = FLUSH;
      end
      FLUSH: begin
        o_flush        = 1'b1;
        o_stall        = 1'b1;
        o_is_eret      = eret_q;
        o_except_cause = eret_q ? CAUSE_NONE : cause_q;
        state_d        = REDIRECT;
      end
      REDIRECT: begin
        o_stall          = 1'b1;
        o_redirect_valid = 1'b1;
        if (i_fetch_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_current_pc       = pc_q;
  assign o_is_in_delay_slot = slot_q;
  assign o_redirect_pc      = redirect_pc_q;

endmodule

// File: tb/tb_except_ctrl.sv
// tb/tb_except_ctrl.sv - directed self-checking bench for except_ctrl

module tb_except_ctrl;

  logic        clk;
  logic        resetn;
  logic        i_valid;
  logic [31:0] i_pc;
  logic        i_is_in_delay_slot;
  logic [6:0]  i_exc_flags;
  logic        i_is_eret;
  logic [5:0]  i_ext_int;
  logic        i_timer_int;
  logic [31:0] i_status_reg;
  logic [31:0] i_cause_reg;
  logic [31:0] i_epc_reg;
  logic        i_fetch_ready;
  logic [5:0]  o_int;
  logic [4:0]  o_except_cause;
  logic [31:0] o_current_pc;
  logic        o_is_in_delay_slot;
  logic        o_is_eret;
  logic        o_flush;
  logic        o_stall;
  logic        o_redirect_valid;
  logic [31:0] o_redirect_pc;

  int vectors;
  int miscompares;

  except_ctrl dut (
    .clk                (clk),
    .resetn             (resetn),
    .i_valid            (i_valid),
    .i_pc               (i_pc),
    .i_is_in_delay_slot (i_is_in_delay_slot),
    .i_exc_flags        (i_exc_flags),
    .i_is_eret          (i_is_eret),
    .i_ext_int          (i_ext_int),
    .i_timer_int        (i_timer_int),
    .i_status_reg       (i_status_reg),
    .i_cause_reg        (i_cause_reg),
    .i_epc_reg          (i_epc_reg),
    .i_fetch_ready      (i_fetch_ready),
    .o_int              (o_int),
    .o_except_cause     (o_except_cause),
    .o_current_pc       (o_current_pc),
    .o_is_in_delay_slot (o_is_in_delay_slot),
    .o_is_eret          (o_is_eret),
    .o_flush            (o_flush),
    .o_stall            (o_stall),
    .o_redirect_valid   (o_redirect_valid),
    .o_redirect_pc      (o_redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one instruction to the memory stage for a single cycle.
  task automatic fire(input logic [31:0] pc, input logic [6:0] flags, input logic eret);
    i_valid     = 1'b1;
    i_pc        = pc;
    i_exc_flags = flags;
    i_is_eret   = eret;
    step();
    i_valid     = 1'b0;
    i_exc_flags = 7'b0;
    i_is_eret   = 1'b0;
  endtask

  initial begin
    vectors            = 0;
    miscompares        = 0;
    resetn             = 1'b0;
    i_valid            = 1'b0;
    i_pc               = 32'h0;
    i_is_in_delay_slot = 1'b0;
    i_exc_flags        = 7'b0;
    i_is_eret          = 1'b0;
    i_ext_int          = 6'b0;
    i_timer_int        = 1'b0;
    i_status_reg       = 32'h0;
    i_cause_reg        = 32'h0;
    i_epc_reg          = 32'h0;
    i_fetch_ready      = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_cause",   o_except_cause,   32'h1F);
    chk("rst_flush",   o_flush,          32'h0);
    chk("rst_stall",   o_stall,          32'h0);
    chk("rst_rvalid",  o_redirect_valid, 32'h0);
    chk("rst_eret",    o_is_eret,        32'h0);
    chk("rst_rpc",     o_redirect_pc,    32'hBFC0_0380);
    chk("rst_cur_pc",  o_current_pc,     32'h0);
    resetn = 1'b1;
    step();

    // Clean instruction: nothing taken
    i_valid = 1'b1;
    i_pc    = 32'h8000_0000;
    step();
    chk("idle_stall", o_stall, 32'h0);
    chk("idle_flush", o_flush, 32'h0);
    step();
    chk("idle_stall2", o_stall, 32'h0);
    i_valid = 1'b0;

    // Overflow in a delay slot
    i_is_in_delay_slot = 1'b1;
    fire(32'h8000_0010, 7'b0000100, 1'b0);
    i_is_in_delay_slot = 1'b0;
    chk("ov_flush",  o_flush,            32'h1);
    chk("ov_cause",  o_except_cause,     32'd12);
    chk("ov_pc",     o_current_pc,       32'h8000_0010);
    chk("ov_slot",   o_is_in_delay_slot, 32'h1);
    chk("ov_stall",  o_stall,            32'h1);
    chk("ov_rv0",    o_redirect_valid,   32'h0);
    step();
    chk("ov_rv",     o_redirect_valid,   32'h1);
    chk("ov_rpc",    o_redirect_pc,      32'hBFC0_0380);
    chk("ov_flush1", o_flush,            32'h0);
    chk("ov_cause1", o_except_cause,     32'h1F);
    chk("ov_stall1", o_stall,            32'h1);
    step();
    chk("ov_idle_rv",    o_redirect_valid, 32'h0);
    chk("ov_idle_stall", o_stall,          32'h0);

    // Interrupt beats a simultaneous RI
    i_status_reg = 32'h0000_0401;
    i_cause_reg  = 32'h0000_0400;
    i_ext_int    = 6'b000001;
    step();
    step();
    chk("int_oint", o_int, 32'h01);
    fire(32'h8000_0020, 7'b0100000, 1'b0);
    chk("int_cause", o_except_cause, 32'd0);
    chk("int_pc",    o_current_pc,   32'h8000_0020);
    chk("int_flush", o_flush,        32'h1);
    step();
    chk("int_rpc", o_redirect_pc, 32'hBFC0_0380);
    i_status_reg = 32'h0;
    i_cause_reg  = 32'h0;
    i_ext_int    = 6'b0;
    step();
    chk("int_idle", o_stall, 32'h0);

    // ERET with redirect held three cycles
    i_epc_reg = 32'h8000_1234;
    fire(32'h8000_0040, 7'b0, 1'b1);
    i_fetch_ready = 1'b0;
    chk("eret_flag",  o_is_eret,      32'h1);
    chk("eret_cause", o_except_cause, 32'h1F);
    chk("eret_flush", o_flush,        32'h1);
    step();
    i_epc_reg = 32'h0;
    chk("eret_rv1",  o_redirect_valid, 32'h1);
    chk("eret_rpc1", o_redirect_pc,    32'h8000_1234);
    chk("eret_e1",   o_is_eret,        32'h0);
    step();
    chk("eret_rv2",  o_redirect_valid, 32'h1);
    chk("eret_rpc2", o_redirect_pc,    32'h8000_1234);
    step();
    chk("eret_rv3",  o_redirect_valid, 32'h1);
    chk("eret_rpc3", o_redirect_pc,    32'h8000_1234);
    i_fetch_ready = 1'b1;
    step();
    chk("eret_idle_rv",    o_redirect_valid, 32'h0);
    chk("eret_idle_stall", o_stall,          32'h0);

    // ERET with adel_mem is the fault
    i_epc_reg = 32'h8000_5678;
    fire(32'h8000_0050, 7'b0000010, 1'b1);
    chk("ef_cause", o_except_cause, 32'd4);
    chk("ef_eret",  o_is_eret,      32'h0);
    step();
    chk("ef_rpc", o_redirect_pc, 32'hBFC0_0380);
    step();

    // Fault priority
    fire(32'h8000_0060, 7'b0011100, 1'b0);
    chk("prio_sys", o_except_cause, 32'd8);
    step();
    step();
    fire(32'h8000_0070, 7'b1000100, 1'b0);
    chk("prio_adel_if", o_except_cause, 32'd4);
    step();
    step();
    fire(32'h8000_0080, 7'b0000001, 1'b0);
    chk("prio_ades", o_except_cause, 32'd5);
    step();
    step();

    // EXL masks the interrupt; timer drives line 5
    i_status_reg = 32'h0000_0403;
    i_cause_reg  = 32'h0000_0400;
    i_ext_int    = 6'b000001;
    i_valid      = 1'b1;
    step();
    chk("exl_stall", o_stall, 32'h0);
    step();
    chk("exl_flush", o_flush, 32'h0);
    i_timer_int = 1'b1;
    #1;
    chk("timer_oint", o_int, 32'h21);
    i_valid      = 1'b0;
    i_timer_int  = 1'b0;
    i_status_reg = 32'h0;
    i_cause_reg  = 32'h0;
    i_ext_int    = 6'b0;
    step();

    // Reset during REDIRECT
    i_fetch_ready = 1'b0;
    fire(32'h8000_0090, 7'b0000100, 1'b0);
    step();
    chk("rr_rv", o_redirect_valid, 32'h1);
    resetn = 1'b0;
    step();
    chk("rr_rv0",    o_redirect_valid, 32'h0);
    chk("rr_stall0", o_stall,          32'h0);
    chk("rr_flush0", o_flush,          32'h0);
    chk("rr_rpc",    o_redirect_pc,    32'hBFC0_0380);
    resetn = 1'b1;
    step();
    chk("rr_after_flush", o_flush,          32'h0);
    chk("rr_after_rv",    o_redirect_valid, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
